// File: rtl/acc_tile_sender_pkg.sv
// rtl/acc_tile_sender_pkg.sv - shared state enum and default widths for acc_tile_sender
package acc_tile_sender_pkg;

  localparam int DATA_WIDTH_DEF        = 32;
  localparam int GROUP_SIZE_DEF        = 4;
  localparam int GROUP_COUNT_WIDTH_DEF = 2;
  localparam int MAX_OUTSTANDING_DEF   = 4;
  localparam int CREDIT_WIDTH_DEF      = 3;
  localparam int TILE_COUNT_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/acc_tile_sender_counter.sv
// rtl/acc_tile_sender_counter.sv - clearable enable counter that wraps after last_val
module mod_counter #(
  parameter int Width = 2
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] last_val,
  output logic [Width-1:0] cnt,
  output logic             tc
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last_val);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_tile_sender.sv
// rtl/acc_tile_sender.sv - credit-gated tile sequencer feeding an FP accumulator
module acc_tile_sender
  import acc_tile_sender_pkg::*;
#(
  parameter int DataWidth       = DATA_WIDTH_DEF,
  parameter int GroupSize       = GROUP_SIZE_DEF,
  parameter int GroupCountWidth = GROUP_COUNT_WIDTH_DEF,
  parameter int MaxOutstanding  = MAX_OUTSTANDING_DEF,
  parameter int CreditWidth     = CREDIT_WIDTH_DEF,
  parameter int TileCountWidth  = TILE_COUNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      aclr_n,
  input  logic                      sclr,
  input  logic                      Start,
  input  logic [TileCountWidth-1:0] TileCount,
  output logic                      Busy,
  output logic                      Done,
  input  logic                      SrcValid,
  input  logic [DataWidth-1:0]      SrcData,
  output logic                      SrcRdy,
  output logic                      AccInValid,
  output logic [DataWidth-1:0]      AccInData,
  input  logic                      AccInRdy,
  input  logic                      AccOutValid,
  input  logic [DataWidth-1:0]      AccOutData,
  output logic                      AccOutRdy,
  output logic                      ResValid,
  output logic [DataWidth-1:0]      ResData,
  output logic                      ResLast,
  input  logic                      ResRdy
);

  localparam logic [CreditWidth-1:0]     CreditsFull = CreditWidth'(MaxOutstanding);
  localparam logic [GroupCountWidth-1:0] WordLast    = GroupCountWidth'(GroupSize - 1);

  state_e                    state_q, state_d;
  logic [TileCountWidth-1:0] tile_count_q, tile_count_d;
  logic [CreditWidth-1:0]    credits_q, credits_d;
  logic                      done_q, done_d;

  logic [GroupCountWidth-1:0] word_cnt;
  logic [TileCountWidth-1:0]  tiles_sent, res_cnt, tile_last;
  logic word_tc, tiles_tc, res_tc;
  logic in_send, ret_active, gate, start_job, cnt_clr;
  logic send_hs, res_hs, credit_take;

  assign in_send    = (state_q == ST_SEND);
  assign ret_active = (state_q == ST_SEND) || (state_q == ST_DRAIN);
  assign start_job  = (state_q == ST_IDLE) && Start && (TileCount != '0);
  assign cnt_clr    = sclr || start_job;
  assign tile_last  = tile_count_q - TileCountWidth'(1);

  // A tile may start only with a free output-buffer credit; words inside a tile never stall on credits.
  assign gate        = (word_cnt != '0) || (credits_q != '0);
  assign send_hs     = in_send && SrcValid && AccInRdy && gate;
  assign res_hs      = ret_active && AccOutValid && ResRdy;
  assign credit_take = send_hs && (word_cnt == '0);

  assign AccInValid = in_send && SrcValid && gate;
  assign SrcRdy     = in_send && AccInRdy && gate;
  assign AccInData  = SrcData;
  assign ResValid   = ret_active && AccOutValid;
  assign AccOutRdy  = ret_active && ResRdy;
  assign ResData    = AccOutData;
  assign ResLast    = ret_active && res_tc;
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = done_q;

  mod_counter #(.Width(GroupCountWidth)) u_word_cnt (
    .clk(clk), .aclr_n(aclr_n), .clr(cnt_clr), .en(send_hs),
    .last_val(WordLast), .cnt(word_cnt), .tc(word_tc)
  );

  mod_counter #(.Width(TileCountWidth)) u_tiles_sent (
    .clk(clk), .aclr_n(aclr_n), .clr(cnt_clr), .en(send_hs && word_tc),
    .last_val(tile_last), .cnt(tiles_sent), .tc(tiles_tc)
  );

  mod_counter #(.Width(TileCountWidth)) u_res_cnt (
    .clk(clk), .aclr_n(aclr_n), .clr(cnt_clr), .en(res_hs),
    .last_val(tile_last), .cnt(res_cnt), .tc(res_tc)
  );

  always_comb begin
    state_d      = state_q;
    tile_count_d = tile_count_q;
    credits_d    = credits_q;
    done_d       = 1'b0;
    if (credit_take && !res_hs) begin
      credits_d = credits_q - CreditWidth'(1);
    end else if (res_hs && !credit_take) begin
      credits_d = credits_q + CreditWidth'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (TileCount != '0) begin
            state_d      = ST_SEND;
            tile_count_d = TileCount;
            credits_d    = CreditsFull;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (send_hs && word_tc && tiles_tc) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_hs && res_tc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (sclr) begin
      state_d      = ST_IDLE;
      tile_count_d = '0;
      credits_d    = CreditsFull;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q      <= ST_IDLE;
      tile_count_q <= '0;
      credits_q    <= CreditsFull;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_count_q <= tile_count_d;
      credits_q    <= credits_d;
      done_q       <= done_d;
    end
  end

  credits_no_underflow: assert property (@(posedge clk) disable iff (!aclr_n)
    !(credit_take && !res_hs && credits_q == '0));
  credits_no_overflow: assert property (@(posedge clk) disable iff (!aclr_n)
    !(res_hs && !credit_take && credits_q == CreditsFull));
  // A result can never be returned for a tile that has not been fully sent.
  results_follow_tiles: assert property (@(posedge clk) disable iff (!aclr_n)
    !(in_send && res_cnt > tiles_sent));

endmodule

// File: tb/tb_acc_tile_sender.sv
// tb/tb_acc_tile_sender.sv - scoreboard bench with behavioural accumulator model
module tb_acc_tile_sender;

  localparam int GS = 4;
  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        aclr_n, sclr, Start;
  logic [7:0]  TileCount;
  logic        Busy, Done;
  logic        SrcValid, SrcRdy, AccInValid, AccInRdy, AccOutValid, AccOutRdy;
  logic        ResValid, ResLast, ResRdy;
  logic [31:0] SrcData, AccInData, AccOutData, ResData;

  acc_tile_sender dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .Start(Start), .TileCount(TileCount),
    .Busy(Busy), .Done(Done),
    .SrcValid(SrcValid), .SrcData(SrcData), .SrcRdy(SrcRdy),
    .AccInValid(AccInValid), .AccInData(AccInData), .AccInRdy(AccInRdy),
    .AccOutValid(AccOutValid), .AccOutData(AccOutData), .AccOutRdy(AccOutRdy),
    .ResValid(ResValid), .ResData(ResData), .ResLast(ResLast), .ResRdy(ResRdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] src_words[$];
  logic [31:0] exp_res_q[$];
  logic        exp_last_q[$];
  logic [31:0] acc_out_q[$];
  logic [31:0] acc_part;
  int acc_cnt, src_idx, word_idx, words_rx, results_seen, dones;
  int tiles_started, results_ret, mode;
  bit res_block;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    bit done_exp;
    done_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (!aclr_n) begin
        done_exp = 1'b0;
        continue;
      end
      if (Done || done_exp) check("done_pulse", Done, done_exp);
      if (Done) dones++;
      if (ResValid && ResRdy) begin
        results_seen++;
        if (exp_res_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          check("res_data", ResData, exp_res_q.pop_front());
          check("res_last", ResLast, exp_last_q.pop_front());
        end
      end
      done_exp = (ResValid && ResRdy && ResLast) ||
                 (Start && !Busy && TileCount == 8'd0 && !sclr);
    end
  end

  task automatic drive();
    if (!(SrcValid && !SrcRdy)) begin
      SrcValid = (src_idx < src_words.size()) && (mode == 1 ? $urandom_range(0, 2) != 0 : 1'b1);
    end
    SrcData     = (src_idx < src_words.size()) ? src_words[src_idx] : 32'd0;
    AccInRdy    = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
    ResRdy      = res_block ? 1'b0 : ((mode == 1) ? $urandom_range(0, 1) == 1 : 1'b1);
    AccOutValid = acc_out_q.size() > 0;
    AccOutData  = (acc_out_q.size() > 0) ? acc_out_q[0] : 32'd0;
  endtask

  // One clock: sample handshakes mid-cycle, advance the models after the edge, drive new inputs.
  task automatic step();
    bit s_hs, a_hs, o_hs;
    logic [31:0] a_data;
    @(negedge clk);
    s_hs   = SrcValid && SrcRdy;
    a_hs   = AccInValid && AccInRdy;
    o_hs   = AccOutValid && AccOutRdy;
    a_data = AccInData;
    @(posedge clk);
    #1;
    if (s_hs || a_hs) check("hs_pair", s_hs, a_hs);
    if (a_hs) begin
      if (acc_cnt == 0) begin
        check("credit_gate", (tiles_started - results_ret) < MO, 1);
        tiles_started++;
      end
      check("word_order", a_data, (word_idx < src_words.size()) ? src_words[word_idx] : 32'hx);
      word_idx++;
      words_rx++;
      acc_part = acc_part + a_data;
      acc_cnt++;
      if (acc_cnt == GS) begin
        acc_out_q.push_back(acc_part);
        acc_part = 32'd0;
        acc_cnt  = 0;
      end
    end
    if (o_hs) begin
      void'(acc_out_q.pop_front());
      results_ret++;
    end
    if (s_hs) src_idx++;
    check("credits", dut.credits_q, MO - (tiles_started - results_ret));
    drive();
  endtask

  task automatic clear_model();
    src_words.delete();
    exp_res_q.delete();
    exp_last_q.delete();
    acc_out_q.delete();
    acc_part = 32'd0;
    acc_cnt = 0; src_idx = 0; word_idx = 0;
    tiles_started = 0; results_ret = 0;
    SrcValid = 1'b0; AccOutValid = 1'b0; SrcData = 32'd0; AccOutData = 32'd0;
  endtask

  task automatic start_job(input int tc, input int mode_i, input bit directed);
    logic [31:0] w, sum;
    src_words.delete();
    src_idx = 0; word_idx = 0; words_rx = 0; results_seen = 0;
    mode = mode_i;
    for (int t = 0; t < tc; t++) begin
      sum = 32'd0;
      for (int k = 0; k < GS; k++) begin
        w = directed ? 32'(t * GS + k + 1) : $urandom;
        src_words.push_back(w);
        sum = sum + w;
      end
      exp_res_q.push_back(sum);
      exp_last_q.push_back(t == tc - 1);
    end
    Start = 1'b1;
    TileCount = 8'(tc);
    drive();
    step();
    Start = 1'b0;
    check("busy_after_start", Busy, tc != 0);
  endtask

  task automatic wait_done(input string name, input int tc, input int dones0, input int budget);
    int k;
    k = 0;
    while (dones == dones0 && k < budget) begin
      step();
      k++;
    end
    if (dones == dones0) begin
      $display("FAIL %s_timeout: got no Done after %0d cycles, expected Done", name, budget);
      n_checks++;
      n_fail++;
    end
    check({name, "_busy_low"}, Busy, 0);
    check({name, "_done_width"}, Done, 0);
    step();
    step();
    check({name, "_done_count"}, dones - dones0, 1);
    check({name, "_words"}, words_rx, tc * GS);
    check({name, "_results"}, results_seen, tc);
    check({name, "_credits_end"}, dut.credits_q, MO);
  endtask

  task automatic abort_check(input string name);
    check({name, "_credits"}, dut.credits_q, MO);
    check({name, "_busy"}, Busy, 0);
    check({name, "_srcrdy"}, SrcRdy, 0);
    check({name, "_resvalid"}, ResValid, 0);
    check({name, "_wordcnt"}, dut.word_cnt, 0);
    check({name, "_rescnt"}, dut.res_cnt, 0);
  endtask

  initial begin : stimulus
    int d0;
    aclr_n = 1'b0; sclr = 1'b0; Start = 1'b0; TileCount = 8'd0;
    AccInRdy = 1'b0; ResRdy = 1'b0; res_block = 1'b0; mode = 0;
    dones = 0; words_rx = 0; results_seen = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_srcrdy", SrcRdy, 0);
    check("rst_accinvalid", AccInValid, 0);
    check("rst_accoutrdy", AccOutRdy, 0);
    check("rst_resvalid", ResValid, 0);
    check("rst_reslast", ResLast, 0);
    check("rst_credits", dut.credits_q, MO);
    aclr_n = 1'b1;
    drive();
    step();

    // Single tile, words 1..4, expecting one result of 10.
    d0 = dones;
    start_job(1, 0, 1'b1);
    check("t1_expected_sum", exp_res_q.size() > 0 ? exp_res_q[0] : 32'd0, 32'd10);
    wait_done("t1", 1, d0, 50);

    // Six tiles with downstream stalled: only four tiles may enter.
    d0 = dones;
    res_block = 1'b1;
    start_job(6, 0, 1'b0);
    repeat (60) step();
    check("t2_words_stalled", words_rx, 16);
    check("t2_srcrdy_stalled", SrcRdy, 0);
    check("t2_wordcnt_zero", dut.word_cnt, 0);
    check("t2_credits_zero", dut.credits_q, 0);
    res_block = 1'b0;
    wait_done("t2", 6, d0, 200);

    // Randomly throttled run.
    d0 = dones;
    start_job(20, 1, 1'b0);
    wait_done("t3", 20, d0, 3000);

    // Zero tiles completes immediately without sending.
    d0 = dones;
    start_job(0, 0, 1'b0);
    wait_done("t4", 0, d0, 10);

    // Maximum tile count must not wrap the tile counters.
    d0 = dones;
    start_job(255, 0, 1'b0);
    wait_done("t5", 255, d0, 2000);

    // Asynchronous reset mid-job, then a clean second job.
    d0 = dones;
    start_job(10, 1, 1'b0);
    repeat (15) step();
    aclr_n = 1'b0;
    clear_model();
    #1;
    abort_check("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    aclr_n = 1'b1;
    drive();
    step();
    start_job(3, 1, 1'b0);
    wait_done("t6", 3, d0, 500);

    // Synchronous clear mid-job behaves like reset.
    d0 = dones;
    start_job(8, 0, 1'b0);
    repeat (7) step();
    sclr = 1'b1;
    SrcValid = 1'b0;
    AccOutValid = 1'b0;
    @(posedge clk);
    #1;
    sclr = 1'b0;
    clear_model();
    abort_check("t7_sclr");
    drive();
    step();
    start_job(2, 1, 1'b0);
    wait_done("t7", 2, d0, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_tile_sender.md
# acc_tile_sender

Initiator-side tile sequencer that drives the FP accumulator's input stream and collects its results. On a Start command it forwards exactly TileCount × GroupSize partial-sum words from an upstream source into the accumulator. It holds back the first word of each new tile until an output-buffer credit is free. It returns one accumulated result per tile downstream, flagging the last one, and pulses Done when the final result has been accepted.

## Interface
- DataWidth, 32, word width of partial sums and results
- GroupSize, 4, words per tile; must equal the accumulator's per-tile count
- GroupCountWidth, 2, width of the word-in-tile counter (≥ clog2(GroupSize))
- MaxOutstanding, 4, credits; equals the accumulator output-buffer depth
- CreditWidth, 3, width of the credit counter (holds 0..MaxOutstanding)
- TileCountWidth, 8, width of the tile count

- clk  in  1  single clock, rising edge
- aclr_n  in  1  asynchronous active-low reset
- sclr  in  1  synchronous clear, same effect as reset
- Start  in  1  command strobe, sampled only in IDLE
- TileCount  in  TileCountWidth  tiles to process, latched on Start
- Busy  out  1  high in SEND or DRAIN
- Done  out  1  one-cycle completion pulse
- SrcValid / SrcData / SrcRdy  in / in[DataWidth] / out  upstream partial-sum stream
- AccInValid / AccInData / AccInRdy  out / out[DataWidth] / in  to the accumulator input
- AccOutValid / AccOutData / AccOutRdy  in / in[DataWidth] / out  from the accumulator output
- ResValid / ResData / ResLast / ResRdy  out / out[DataWidth] / out / in  downstream result stream

## Operation
- Handshake occurs when valid & ready are both high on a rising edge. A source may not drop valid before the handshake.
- FSM states: IDLE, SEND, DRAIN.
- IDLE:
  - Start with TileCount≠0 latches TileCount, clears all counters, and moves to SEND.
  - Start with TileCount=0 stays in IDLE and pulses Done on the next cycle.
- Send path (SEND only):
  - Gate = (WordCnt≠0) | (Credits≠0).
  - AccInValid = SrcValid & Gate; SrcRdy = AccInRdy & Gate; AccInData = SrcData (combinational).
- Send handshake:
  - WordCnt increments and wraps from GroupSize−1 to 0.
  - On the first word of a tile (WordCnt=0), Credits decrements.
  - On the last word (WordCnt=GroupSize−1), TilesSent increments.
  - If TilesSent reaches TileCount, move to DRAIN.
- Return path (SEND or DRAIN):
  - ResValid = AccOutValid; ResData = AccOutData; AccOutRdy = ResRdy.
  - ResLast = (ResCnt == TileCount−1).
  - Each result handshake increments Credits and ResCnt.
- A credit consumed and a credit returned in the same cycle leave Credits unchanged.
- In IDLE: SrcRdy, AccInValid, AccOutRdy, and ResValid are all 0, so stray accumulator results wait.
- DRAIN: the ResLast handshake moves to IDLE and pulses Done on the next cycle.
- Start while Busy is ignored.

## Timing
- Reset/sclr values:
  - State IDLE; WordCnt, TilesSent, ResCnt = 0; Credits = MaxOutstanding.
  - Busy, Done, SrcRdy, AccInValid, AccOutRdy, ResValid, ResLast = 0.
- Reset mid-operation abandons the job with no Done. The accumulator must be reset together with this block.
- Data paths have zero added latency (pure combinational forwarding). Only state and counters are registered.
- Busy rises the cycle after Start and falls in the cycle Done is high.
- Done is a registered pulse, high exactly one cycle after the final result handshake.
- Credits never underflow below 0 or exceed MaxOutstanding; either event is an assertion failure.
- TilesSent and ResCnt compare against the latched TileCount. TileCount = 2^TileCountWidth−1 must work with no wrap.

## Structure
- Shared package: the state enum (IDLE/SEND/DRAIN) and the default width constants.
- One natural sub-module: mod_counter, a clearable enable counter with terminal-count output. Instantiate it for WordCnt, TilesSent, and ResCnt.
- The credit up/down counter is inline.

## Test plan
- TileCount=1, GroupSize=4, words 1.0,2.0,3.0,4.0, no stalls → accumulator sees 4 words; one result 10.0 with ResLast=1; Done one cycle later; Busy low.
- TileCount=6, ResRdy held 0:
  - exactly 4 tiles (16 words) are sent, then SrcRdy stays 0 at WordCnt=0;
  - releasing ResRdy lets the remaining 2 tiles flow, and ResLast is set on the 6th result.
- Random AccInRdy/SrcValid/ResRdy throttling, TileCount=20 → word order preserved, 20 results, Credits back at 4, one Done.
- Credit consumed and returned in the same cycle → Credits unchanged (check 2→2).
- Start with TileCount=0 → Done pulse next cycle, no words sent.
- aclr_n low mid-SEND, then a new Start → counters cleared, Credits=4, clean second job, Done only for the second job.
